// File: rtl/fir_mc.sv
// Multichannel time-multiplexed FIR: one shared MAC walks the taps of the
// selected channel's delay line, then rounds half-up and saturates the result.
module fir_mc #(
   parameter int TAPS        = 8,
   parameter int CHANNELS    = 2,
   parameter int IN_WIDTH    = 16,
   parameter int COEFF_WIDTH = 16,
   parameter int FRAC        = 8,
   localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int TAP_W      = (TAPS > 1) ? $clog2(TAPS) : 1,
   localparam int ACC_WIDTH  = IN_WIDTH + COEFF_WIDTH + $clog2(TAPS)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic signed [IN_WIDTH-1:0]    in_sample,
   input  logic        [CH_W-1:0]        in_chan,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          coef_we,
   input  logic        [TAP_W-1:0]       coef_addr,
   input  logic signed [COEFF_WIDTH-1:0] coef_data,
   output logic signed [IN_WIDTH-1:0]    out_sample,
   output logic        [CH_W-1:0]        out_chan,
   output logic                          out_sat,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          chan_err
);

   typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

   localparam logic [TAP_W:0] TAP_LIM  = (TAP_W+1)'(TAPS);
   localparam logic [CH_W:0]  CH_LIM   = (CH_W+1)'(CHANNELS);
   localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
   localparam logic signed [COEFF_WIDTH-1:0] COEF_ONE = COEFF_WIDTH'(2**FRAC);
   localparam logic signed [ACC_WIDTH:0] RND     = (ACC_WIDTH+1)'((2**FRAC) / 2);
   localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'(2**(IN_WIDTH-1) - 1);
   localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH+1)'(-(2**(IN_WIDTH-1)));

   state_t                        state_q;
   logic                          live_q;
   logic signed [IN_WIDTH-1:0]    dly_q [CHANNELS][TAPS];
   logic        [TAP_W-1:0]       wrPtr_q [CHANNELS];
   logic signed [COEFF_WIDTH-1:0] coef_q [TAPS];
   logic signed [ACC_WIDTH-1:0]   acc_q;
   logic        [TAP_W-1:0]       k_q;
   logic        [TAP_W-1:0]       rdIdx_q;
   logic        [CH_W-1:0]        chan_q;
   logic signed [IN_WIDTH-1:0]    outSample_q;
   logic        [CH_W-1:0]        outChan_q;
   logic                          outSat_q;
   logic                          outValid_q;
   logic                          chanErr_q;

   logic signed [IN_WIDTH-1:0]    curSample;
   logic signed [ACC_WIDTH-1:0]   tapSample;
   logic signed [ACC_WIDTH-1:0]   tapCoef;
   logic signed [ACC_WIDTH-1:0]   product;
   logic signed [ACC_WIDTH-1:0]   accNext_d;
   logic signed [ACC_WIDTH:0]     accExt;
   logic signed [ACC_WIDTH:0]     rounded;
   logic signed [ACC_WIDTH:0]     shifted;
   logic signed [IN_WIDTH-1:0]    satSample_d;
   logic                          satFlag_d;
   logic                          chanOk;
   logic                          coefOk;

   // live_q keeps in_ready low through the reset cycle even though state is IDLE.
   assign in_ready   = (state_q == IDLE) && live_q;
   assign out_sample = outSample_q;
   assign out_chan   = outChan_q;
   assign out_sat    = outSat_q;
   assign out_valid  = outValid_q;
   assign chan_err   = chanErr_q;

   assign chanOk = ({1'b0, in_chan} < CH_LIM);
   assign coefOk = ({1'b0, coef_addr} < TAP_LIM);

   // Operands are sign-extended to accumulator width so the product is exact.
   always_comb begin
      curSample = dly_q[chan_q][rdIdx_q];
      tapSample = {{(ACC_WIDTH-IN_WIDTH){curSample[IN_WIDTH-1]}}, curSample};
      tapCoef   = {{(ACC_WIDTH-COEFF_WIDTH){coef_q[k_q][COEFF_WIDTH-1]}}, coef_q[k_q]};
      product   = tapSample * tapCoef;
      accNext_d = acc_q + product;
   end

   // One guard bit absorbs the rounding constant before the arithmetic shift.
   always_comb begin
      accExt  = {acc_q[ACC_WIDTH-1], acc_q};
      rounded = accExt + RND;
      shifted = rounded >>> FRAC;
      satSample_d = shifted[IN_WIDTH-1:0];
      satFlag_d   = 1'b0;
      if (shifted > SAT_MAX) begin
         satSample_d = SAT_MAX[IN_WIDTH-1:0];
         satFlag_d   = 1'b1;
      end else if (shifted < SAT_MIN) begin
         satSample_d = SAT_MIN[IN_WIDTH-1:0];
         satFlag_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         live_q      <= 1'b0;
         acc_q       <= '0;
         k_q         <= '0;
         rdIdx_q     <= '0;
         chan_q      <= '0;
         outSample_q <= '0;
         outChan_q   <= '0;
         outSat_q    <= 1'b0;
         outValid_q  <= 1'b0;
         chanErr_q   <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            wrPtr_q[c] <= '0;
            for (int t = 0; t < TAPS; t++) begin
               dly_q[c][t] <= '0;
            end
         end
         for (int t = 0; t < TAPS; t++) begin
            coef_q[t] <= (t == 0) ? COEF_ONE : '0;
         end
      end else begin
         live_q    <= 1'b1;
         chanErr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (coef_we && coefOk) begin
                  coef_q[coef_addr] <= coef_data;
               end
               if (in_valid && live_q) begin
                  if (chanOk) begin
                     dly_q[in_chan][wrPtr_q[in_chan]] <= in_sample;
                     wrPtr_q[in_chan] <= (wrPtr_q[in_chan] == TAP_LAST) ?
                                         '0 : wrPtr_q[in_chan] + TAP_W'(1);
                     rdIdx_q <= wrPtr_q[in_chan];
                     chan_q  <= in_chan;
                     acc_q   <= '0;
                     k_q     <= '0;
                     state_q <= MAC;
                  end else begin
                     chanErr_q <= 1'b1;
                  end
               end
            end
            // rdIdx_q walks backwards from the newest sample, so tap k pairs with coeff k.
            MAC: begin
               acc_q   <= accNext_d;
               k_q     <= k_q + TAP_W'(1);
               rdIdx_q <= (rdIdx_q == '0) ? TAP_LAST : rdIdx_q - TAP_W'(1);
               if (k_q == TAP_LAST) begin
                  state_q <= ROUND;
               end
            end
            ROUND: begin
               outSample_q <= satSample_d;
               outSat_q    <= satFlag_d;
               outChan_q   <= chan_q;
               outValid_q  <= 1'b1;
               state_q     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mc.sv
// Directed bench for fir_mc (TAPS=8, CHANNELS=3 so an out-of-range tag exists).
module tb_fir_mc;

   logic               clk;
   logic               rstN;
   logic signed [15:0] inSample;
   logic        [1:0]  inChan;
   logic               inValid;
   logic               inReady;
   logic               coefWe;
   logic        [2:0]  coefAddr;
   logic signed [15:0] coefData;
   logic signed [15:0] outSample;
   logic        [1:0]  outChan;
   logic               outSat;
   logic               outValid;
   logic               outReady;
   logic               chanErr;

   int vectorCount = 0;
   int missCount   = 0;

   fir_mc #(
      .TAPS(8), .CHANNELS(3), .IN_WIDTH(16), .COEFF_WIDTH(16), .FRAC(8)
   ) dut (
      .clk(clk), .rst_n(rstN),
      .in_sample(inSample), .in_chan(inChan), .in_valid(inValid), .in_ready(inReady),
      .coef_we(coefWe), .coef_addr(coefAddr), .coef_data(coefData),
      .out_sample(outSample), .out_chan(outChan), .out_sat(outSat),
      .out_valid(outValid), .out_ready(outReady), .chan_err(chanErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rstN = 1'b0; inValid = 1'b0; coefWe = 1'b0; outReady = 1'b1;
      tick();
      tick();
      checkOutput("rst_in_ready", inReady, 0);
      checkOutput("rst_out_valid", outValid, 0);
      checkOutput("rst_out_sample", outSample, 0);
      checkOutput("rst_chan_err", chanErr, 0);
      rstN = 1'b1;
      tick();
      checkOutput("rst_release_ready", inReady, 1);
   endtask

   task automatic writeCoef(input int addr, input int data);
      coefWe = 1'b1; coefAddr = 3'(addr); coefData = 16'(data);
      tick();
      coefWe = 1'b0;
   endtask

   task automatic loadTaps(input int c0, input int c1, input int c2, input int c3,
                           input int c4, input int c5, input int c6, input int c7);
      writeCoef(0, c0); writeCoef(1, c1); writeCoef(2, c2); writeCoef(3, c3);
      writeCoef(4, c4); writeCoef(5, c5); writeCoef(6, c6); writeCoef(7, c7);
   endtask

   task automatic waitIdle();
      int n = 0;
      while (!inReady && n < 50) begin
         tick();
         n++;
      end
      checkOutput("idle_wait", inReady, 1);
   endtask

   task automatic applyStimulus(input logic [1:0] chan, input int sample,
                                input int expSample, input logic expSat);
      int cyc = 0;
      waitIdle();
      inChan = chan; inSample = 16'(sample); inValid = 1'b1; outReady = 1'b1;
      tick();
      inValid = 1'b0;
      checkOutput("busy_ready", inReady, 0);
      while (!outValid && cyc < 40) begin
         tick();
         cyc++;
      end
      checkOutput("latency", cyc, 9);
      checkOutput("out_sample", outSample, expSample);
      checkOutput("out_chan", outChan, chan);
      checkOutput("out_sat", outSat, expSat);
      tick();
      checkOutput("out_valid_clr", outValid, 0);
   endtask

   int  cyc;
   logic sawValid;

   initial begin
      inSample = '0; inChan = '0; inValid = 1'b0; coefWe = 1'b0;
      coefAddr = '0; coefData = '0; outReady = 1'b1; rstN = 1'b0;

      $display("[TB] identity coefficients after reset");
      doReset();
      applyStimulus(0, 100, 100, 0);
      applyStimulus(0, -7, -7, 0);

      $display("[TB] loaded taps, ch1 impulse");
      loadTaps(2, 8, 18, 40, 40, 18, 8, 2);
      applyStimulus(1, 256, 2, 0);
      applyStimulus(1, 0, 8, 0);
      applyStimulus(1, 0, 18, 0);
      applyStimulus(1, 0, 40, 0);
      applyStimulus(1, 0, 40, 0);
      applyStimulus(1, 0, 18, 0);
      applyStimulus(1, 0, 8, 0);
      applyStimulus(1, 0, 2, 0);

      $display("[TB] channel isolation and bad tag");
      doReset();
      loadTaps(2, 8, 18, 40, 40, 18, 8, 2);
      applyStimulus(0, 256, 2, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 8, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 18, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 40, 0);
      applyStimulus(1, 0, 0, 0);
      inChan = 2'd3; inSample = 16'sd999; inValid = 1'b1;
      tick();
      inValid = 1'b0;
      checkOutput("chan_err_pulse", chanErr, 1);
      checkOutput("chan_err_idle", inReady, 1);
      checkOutput("chan_err_no_out", outValid, 0);
      tick();
      checkOutput("chan_err_clear", chanErr, 0);
      checkOutput("chan_err_no_out2", outValid, 0);
      applyStimulus(0, 0, 40, 0);

      $display("[TB] rounding");
      doReset();
      writeCoef(0, 128);
      applyStimulus(0, 3, 2, 0);
      applyStimulus(0, -3, -1, 0);

      $display("[TB] saturation");
      doReset();
      loadTaps(256, 256, 256, 256, 256, 256, 256, 256);
      applyStimulus(0, 10000, 10000, 0);
      applyStimulus(0, 10000, 20000, 0);
      applyStimulus(0, 10000, 30000, 0);
      applyStimulus(0, 10000, 32767, 1);

      $display("[TB] backpressure");
      doReset();
      outReady = 1'b0; inChan = 2'd0; inSample = 16'sd500; inValid = 1'b1;
      tick();
      inValid = 1'b0;
      cyc = 0;
      while (!outValid && cyc < 40) begin
         tick();
         cyc++;
      end
      checkOutput("bp_latency", cyc, 9);
      for (int i = 0; i < 5; i++) begin
         coefWe = (i == 1); coefAddr = 3'd0; coefData = 16'sd512;
         tick();
         coefWe = 1'b0;
         checkOutput("bp_valid_hold", outValid, 1);
         checkOutput("bp_sample_hold", outSample, 500);
         checkOutput("bp_in_ready", inReady, 0);
      end
      outReady = 1'b1;
      tick();
      checkOutput("bp_release", outValid, 0);
      applyStimulus(0, 20, 20, 0);

      $display("[TB] reset during MAC");
      loadTaps(2, 8, 18, 40, 40, 18, 8, 2);
      inChan = 2'd2; inSample = 16'sd256; inValid = 1'b1;
      tick();
      inValid = 1'b0;
      tick();
      tick();
      rstN = 1'b0;
      tick();
      checkOutput("abort_ready", inReady, 0);
      checkOutput("abort_valid", outValid, 0);
      rstN = 1'b1;
      sawValid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (outValid) sawValid = 1'b1;
      end
      checkOutput("abort_no_output", sawValid, 0);
      applyStimulus(2, 256, 256, 0);
      applyStimulus(2, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/fir_mc.md
# fir_mc

Multichannel, time-multiplexed FIR filter: the parametrised successor to the single-channel parallel FIR. It is used where several interleaved sample streams share one multiplier. Each channel has its own delay line. All channels share one runtime-loadable coefficient bank. A single MAC evaluates one tap per cycle, then rounds and saturates the result. The block sits between a channel-tagged sample source and a downstream consumer, with valid/ready handshakes on both sides.

## Interface
- TAPS, 8, filter length (≥2)
- CHANNELS, 2, number of independent delay lines (≥1)
- IN_WIDTH, 16, signed sample width (input and output)
- COEFF_WIDTH, 16, signed coefficient width
- FRAC, 8, coefficient fractional bits (0 ≤ FRAC < COEFF_WIDTH)
- Derived: CH_W = max(1,clog2(CHANNELS)), TAP_W = max(1,clog2(TAPS)), ACC_WIDTH = IN_WIDTH+COEFF_WIDTH+clog2(TAPS)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_sample  in  IN_WIDTH  signed input sample
- in_chan  in  CH_W  channel tag of in_sample
- in_valid  in  1  input valid
- in_ready  out  1  input ready (high only in IDLE)
- coef_we  in  1  coefficient write strobe
- coef_addr  in  TAP_W  tap index to write
- coef_data  in  COEFF_WIDTH  signed coefficient value
- out_sample  out  IN_WIDTH  signed filtered sample
- out_chan  out  CH_W  channel tag of out_sample
- out_sat  out  1  out_sample was saturated
- out_valid  out  1  output valid
- out_ready  in  1  downstream ready
- chan_err  out  1  one-cycle pulse: accepted sample had in_chan ≥ CHANNELS

## Operation
- Delay lines: CHANNELS×TAPS sample registers. Each channel has its own circular write pointer. Tap 0 is the newest sample of that channel.
- Coefficient bank: TAPS registers.
  - Reset value is identity: tap 0 = 2^FRAC, all others 0.
  - A write (coef_we=1, coef_addr<TAPS) is performed only while state is IDLE.
  - coef_we outside IDLE, or with coef_addr ≥ TAPS, is ignored.
- FSM: IDLE → MAC → ROUND → OUT → IDLE.
  - IDLE: in_ready=1. On in_valid, the sample is accepted.
    - Valid channel: the sample is written to that channel's delay line, the pointer advances (wraps TAPS-1→0), acc=0, k=0, and the FSM goes to MAC.
    - Invalid channel: the sample is discarded, chan_err pulses on the next cycle, and the FSM stays in IDLE. No output is produced.
  - MAC: each cycle, acc += sample[ch][k] × coeff[k] (full-precision signed), then k++. After k = TAPS-1 is processed, go to ROUND.
  - ROUND: rounding is half-up, r = (acc + 2^(FRAC-1)) >>> FRAC (no add when FRAC=0).
    - r is saturated to [−2^(IN_WIDTH−1), 2^(IN_WIDTH−1)−1].
    - Register out_sample, out_sat, out_chan; set out_valid=1; go to OUT.
  - OUT: hold all outputs stable while out_ready=0. On out_valid & out_ready, clear out_valid and go to IDLE.
- A coefficient write and an input accept on the same IDLE edge: the new coefficient applies to that sample's computation.
- Reset (rst_n=0 at an edge, any state): FSM→IDLE, aborting any computation with no output.
  - Delay lines, pointers and acc are cleared; coefficients return to identity.
  - out_sample=0, out_chan=0, out_sat=0, out_valid=0, chan_err=0.
  - in_ready reads 0 during the reset cycle and 1 from the first edge with rst_n=1.

## Timing
- Accept on edge E0. MAC occupies edges E1..E_TAPS. ROUND is edge E_TAPS+1, after which out_valid is high. This gives TAPS+1 cycles of latency from accept to out_valid.
- The output handshake takes ≥1 edge. With out_ready tied high, the sample period is TAPS+3 cycles.
- in_ready is combinational from state only, with no path from in_valid.
- out_* are registered, with no combinational path from inputs.
- chan_err is high for exactly one cycle, the cycle after the bad accept edge.

## Test plan
- Reset identity: after reset, ch0 inputs 100, −7 → outputs 100, −7 with out_chan=0, out_sat=0, latency exactly 9 cycles (TAPS=8).
- Loaded taps: write coeffs 2,8,18,40,40,18,8,2; ch1 impulse 256 followed by seven 0s → outputs 2,8,18,40,40,18,8,2 on out_chan=1.
- Channel isolation: interleave ch0 impulse 256 and ch1 constant 0 → ch1 outputs all 0; ch0 sequence unaffected by ch1 traffic. in_chan=3 → chan_err pulse, no output, state stays IDLE.
- Rounding/saturation:
  - coeff0=128, other taps 0: input 3 → 2; input −3 → −1.
  - All coeffs 256, ch0 inputs 10000 ×4 → outputs 10000, 20000, 30000, 32767 with out_sat=1 on the 4th.
- Backpressure: out_ready=0 for 5 cycles in OUT → out_valid, out_sample stable; in_ready=0; coef_we in that window is ignored (verify by readback of the next result).
- Reset mid-MAC: assert rst_n=0 at edge E3 → no out_valid; the next impulse gives the identity response (coeffs reset).
